// File: rtl/fir_pkg.sv
// Shared types and helpers for the polyphase interpolating FIR.
// FIR_INTERP_SAT_EN selects saturating output reduction; otherwise results wrap.
package fir_pkg;

  localparam int QUANT_BITS = 10;
  localparam int WIDE_W     = 128;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  // Drops QUANT_BITS fraction bits; the caller keeps the low dw bits of the result.
  function automatic wide_t dequantize(input wide_t acc, input int dw);
    wide_t shifted;
    shifted = acc >>> QUANT_BITS;
`ifdef FIR_INTERP_SAT_EN
    begin
      wide_t max_v;
      wide_t min_v;
      max_v = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
      min_v = -max_v - wide_t'(1);
      if (shifted > max_v)      shifted = max_v;
      else if (shifted < min_v) shifted = min_v;
    end
`else
    shifted = shifted & ((wide_t'(1) <<< dw) - wide_t'(1));
`endif
    return shifted;
  endfunction

endpackage

// File: rtl/fir_interp_if.sv
// Sample source/sink bundle between the FIR core and its FIFOs.
// Source is first-word-fall-through: x_in is valid while !x_empty and is taken in the
// cycle x_rd_en is high. Sink accepts y_out in any cycle y_wr_en is high; y_wr_en is
// only raised while y_out_full is low.
interface fir_interp_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] x_in;
  logic                  x_empty;
  logic                  x_rd_en;
  logic [DATA_WIDTH-1:0] y_out;
  logic                  y_out_full;
  logic                  y_wr_en;

  modport master (output x_in, x_empty, y_out_full, input x_rd_en, y_out, y_wr_en);
  modport slave  (input x_in, x_empty, y_out_full, output x_rd_en, y_out, y_wr_en);
endinterface

// File: rtl/fir_interp_mac.sv
// Registered signed multiply-accumulate with synchronous clear.
// sum_o is the value the accumulator takes on the next enabled edge.
module fir_interp_mac #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clr_i,
  input  logic                          en_i,
  input  logic signed [DATA_WIDTH-1:0]  a_i,
  input  logic signed [DATA_WIDTH-1:0]  b_i,
  output logic signed [2*DATA_WIDTH-1:0] sum_o
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [2*DATA_WIDTH-1:0] acc_d;
  logic signed [2*DATA_WIDTH-1:0] acc_q;

  always_comb begin
    prod  = a_i * b_i;
    sum_o = acc_q + prod;
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = sum_o;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/fir_interp_top.sv
// fir_interp wrapped with 1024-deep, 32-bit first-word-fall-through FIFOs on both sides.
// FIR_INTERP_SAT_EN is honoured by the wrapped core.
module fir_interp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr;
  logic             do_rd;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

endmodule

module fir_interp_top
  import fir_pkg::*;
#(
  parameter int                 TAPS   = 32,
  parameter int                 INTERP = 4,
  parameter logic [TAPS*32-1:0] COEFF  = '0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_wr_en_i,
  input  logic [31:0] in_data_i,
  output logic        in_full_o,
  input  logic        out_rd_en_i,
  output logic [31:0] out_data_o,
  output logic        out_empty_o,
  output state_e      state_o
);

  fir_interp_if #(.DATA_WIDTH(32)) core_if ();

  fir_interp_fifo #(.WIDTH(32), .DEPTH(1024)) u_in_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (in_wr_en_i),
    .wr_data_i (in_data_i),
    .full_o    (in_full_o),
    .rd_en_i   (core_if.x_rd_en),
    .rd_data_o (core_if.x_in),
    .empty_o   (core_if.x_empty)
  );

  fir_interp #(.DATA_WIDTH(32), .TAPS(TAPS), .INTERP(INTERP), .COEFF(COEFF)) u_core (
    .clock   (clock),
    .reset   (reset),
    .io      (core_if.slave),
    .state_o (state_o)
  );

  fir_interp_fifo #(.WIDTH(32), .DEPTH(1024)) u_out_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (core_if.y_wr_en),
    .wr_data_i (core_if.y_out),
    .full_o    (core_if.y_out_full),
    .rd_en_i   (out_rd_en_i),
    .rd_data_o (out_data_o),
    .empty_o   (out_empty_o)
  );

endmodule

// File: rtl/fir_interp.sv
// Polyphase zero-stuffed interpolating FIR: one input yields INTERP outputs, each a
// PT-tap dot product computed serially. FIR_INTERP_SAT_EN enables output saturation.
module fir_interp
  import fir_pkg::*;
#(
  parameter int                         DATA_WIDTH = 32,
  parameter int                         TAPS       = 32,
  parameter int                         INTERP     = 4,
  parameter logic [TAPS*DATA_WIDTH-1:0] COEFF      = '0
) (
  input  logic           clock,
  input  logic           reset,
  fir_interp_if.slave    io,
  output state_e         state_o
);

  localparam int PT  = TAPS / INTERP;
  localparam int K_W = (PT > 1) ? $clog2(PT) : 1;
  localparam int P_W = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam int I_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  state_e                        state_q;
  logic [K_W-1:0]                k_q;
  logic [P_W-1:0]                p_q;
  logic [DATA_WIDTH-1:0]         y_q;
  logic signed [DATA_WIDTH-1:0]  hist_q [PT];

  logic signed [DATA_WIDTH-1:0]  h [TAPS];
  logic [I_W-1:0]                coef_idx;
  logic signed [2*DATA_WIDTH-1:0] mac_sum;
  wide_t                         deq;
  logic                          unused_deq_hi;

  // h[0] sits in the most significant word of COEFF.
  for (genvar i = 0; i < TAPS; i++) begin : g_coef
    assign h[i] = COEFF[(TAPS-1-i)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign coef_idx = I_W'(k_q) * I_W'(INTERP) + I_W'(p_q);

  fir_interp_mac #(.DATA_WIDTH(DATA_WIDTH)) u_mac (
    .clock (clock),
    .reset (reset),
    .clr_i (state_q != S_MAC),
    .en_i  (state_q == S_MAC),
    .a_i   (h[coef_idx]),
    .b_i   (hist_q[k_q]),
    .sum_o (mac_sum)
  );

  assign deq           = dequantize(wide_t'(mac_sum), DATA_WIDTH);
  assign unused_deq_hi = ^deq[WIDE_W-1:DATA_WIDTH];

  // Read strobe is held off during reset so a waiting sample is never popped early.
  assign io.x_rd_en = reset && (state_q == S_READ) && !io.x_empty;
  assign io.y_wr_en = (state_q == S_WRITE) && !io.y_out_full;
  assign io.y_out   = y_q;
  assign state_o    = state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_READ;
      k_q     <= '0;
      p_q     <= '0;
      y_q     <= '0;
      for (int i = 0; i < PT; i++) hist_q[i] <= '0;
    end else begin
      case (state_q)
        S_READ: begin
          if (!io.x_empty) begin
            hist_q[0] <= io.x_in;
            for (int i = 1; i < PT; i++) hist_q[i] <= hist_q[i-1];
            k_q     <= '0;
            p_q     <= '0;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          if (k_q == K_W'(PT - 1)) begin
            y_q     <= deq[DATA_WIDTH-1:0];
            state_q <= S_WRITE;
          end else begin
            k_q <= k_q + K_W'(1);
          end
        end
        S_WRITE: begin
          if (!io.y_out_full) begin
            if (p_q == P_W'(INTERP - 1)) begin
              state_q <= S_READ;
            end else begin
              p_q     <= p_q + P_W'(1);
              k_q     <= '0;
              state_q <= S_MAC;
            end
          end
        end
        default: state_q <= S_READ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp.sv
// Directed bench for fir_interp: TAPS=8, INTERP=4, h[i]=(i+1)*1024, plus a
// saturation instance with h[0]=0x7fffffff.
module tb_fir_interp;
  import fir_pkg::*;

  localparam int DW     = 32;
  localparam int TAPS   = 8;
  localparam int INTERP = 4;
  localparam int PT     = TAPS / INTERP;
  localparam logic [TAPS*DW-1:0] COEFF_A = {32'd1024, 32'd2048, 32'd3072, 32'd4096,
                                            32'd5120, 32'd6144, 32'd7168, 32'd8192};
  localparam logic [TAPS*DW-1:0] COEFF_S = {32'h7fffffff, {((TAPS-1)*DW){1'b0}}};
`ifdef FIR_INTERP_SAT_EN
  localparam logic [DW-1:0] SAT_EXP = 32'h7fffffff;
`else
  localparam logic [DW-1:0] SAT_EXP = 32'hffc00000;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fir_interp_if #(.DATA_WIDTH(DW)) if_a ();
  fir_interp_if #(.DATA_WIDTH(DW)) if_s ();
  state_e state_a;
  state_e state_s;

  fir_interp #(.DATA_WIDTH(DW), .TAPS(TAPS), .INTERP(INTERP), .COEFF(COEFF_A)) dut_a (
    .clock (clock), .reset (reset), .io (if_a.slave), .state_o (state_a));

  fir_interp #(.DATA_WIDTH(DW), .TAPS(TAPS), .INTERP(INTERP), .COEFF(COEFF_S)) dut_s (
    .clock (clock), .reset (reset), .io (if_s.slave), .state_o (state_s));

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] src_q[$];
  int rd_cyc[$];
  int wr_cyc[$];
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int bad_rd = 0;
  int overlap = 0;
  logic take;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Source FIFO model and output monitor for dut_a.
  initial begin
    if_a.x_empty = 1'b1;
    if_a.x_in    = '0;
    forever begin
      @(negedge clock);
      cyc++;
      take = if_a.x_rd_en;
      if (if_a.x_rd_en) rd_cyc.push_back(cyc);
      if (if_a.x_rd_en && if_a.x_empty) bad_rd++;
      if (if_a.x_rd_en && if_a.y_wr_en) overlap++;
      if (if_a.y_wr_en) begin
        got_q.push_back(if_a.y_out);
        wr_cyc.push_back(cyc);
      end
      @(posedge clock);
      #1;
      if (take && src_q.size() > 0) void'(src_q.pop_front());
      if_a.x_empty = (src_q.size() == 0);
      if_a.x_in    = (src_q.size() > 0) ? src_q[0] : '0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input int first, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back(DW'(first + i));
  endtask

  task automatic push_zeros(input int count);
    for (int i = 0; i < count; i++) exp_q.push_back('0);
  endtask

  task automatic wait_state_a(input state_e s, input string tag);
    int n = 0;
    while (state_a != s && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (state_a != s) check({tag, "_timeout"}, int'(state_a), int'(s));
  endtask

  task automatic wait_outputs(input int n, input string tag);
    int c = 0;
    while (got_q.size() < n && c < 1000) begin
      @(negedge clock);
      c++;
    end
    if (got_q.size() < n) check({tag, "_timeout"}, got_q.size(), n);
  endtask

  task automatic compare_stream(input string tag);
    logic [DW-1:0] e;
    logic [DW-1:0] g;
    int idx = 0;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front();
      else                  g = '1;
      check($sformatf("%s_y%0d", tag, idx), g, e);
      idx++;
    end
    got_q.delete();
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    rd_cyc.delete();
    wr_cyc.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int stall_wr;
    int y_changes;
    int n_rd;
    int n_wr;
    int c;
    logic [DW-1:0] hold;

    if_a.y_out_full = 1'b0;
    if_s.y_out_full = 1'b0;
    if_s.x_empty    = 1'b1;
    if_s.x_in       = '0;

    // Reset: a sample is already waiting, yet nothing may be popped.
    src_q.push_back(1);
    repeat (3) @(negedge clock);
    check("rst_state", int'(state_a), int'(S_READ));
    check("rst_y_out", if_a.y_out, 0);
    check("rst_wr_en", int'(if_a.y_wr_en), 0);
    check("rst_rd_en", int'(if_a.x_rd_en), 0);

    // Impulse 1,0,0 -> 1..8 then four zeros.
    @(posedge clock); #1;
    reset = 1'b1;
    src_q.push_back(0);
    src_q.push_back(0);
    push_exp(1, 8);
    push_zeros(4);
    wait_outputs(12, "imp");
    tick(20);
    if (rd_cyc.size() >= 2 && wr_cyc.size() >= 1) begin
      check("imp_latency", wr_cyc[0] - rd_cyc[0], PT + 1);
      check("imp_throughput", rd_cyc[1] - rd_cyc[0], INTERP * (PT + 1) + 1);
    end else begin
      check("imp_events", rd_cyc.size(), 3);
    end
    compare_stream("imp");
    clear_sb();

    // Backpressure: sink full for the first output's S_WRITE.
    if_a.y_out_full = 1'b1;
    src_q.push_back(1);
    src_q.push_back(0);
    src_q.push_back(0);
    push_exp(1, 8);
    push_zeros(4);
    wait_state_a(S_WRITE, "bp_write");
    hold      = if_a.y_out;
    stall_wr  = 0;
    y_changes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (if_a.y_wr_en) stall_wr++;
      if (if_a.y_out != hold) y_changes++;
    end
    check("bp_hold_value", hold, 1);
    check("bp_wr_during_full", stall_wr, 0);
    check("bp_y_out_changes", y_changes, 0);
    check("bp_still_write", int'(state_a), int'(S_WRITE));
    tick(1);
    if_a.y_out_full = 1'b0;
    wait_outputs(12, "bp");
    tick(20);
    compare_stream("bp");
    clear_sb();

    // Empty source: nothing may move for 50 cycles.
    n_rd = 0;
    n_wr = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (if_a.x_rd_en) n_rd++;
      if (if_a.y_wr_en) n_wr++;
    end
    check("empty_rd_en", n_rd, 0);
    check("empty_wr_en", n_wr, 0);

    // Reset in S_MAC of input 1, then re-feed 1,0.
    tick(1);
    src_q.push_back(1);
    wait_state_a(S_MAC, "rst_mac");
    check("rst_no_early_out", got_q.size(), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    src_q.delete();
    @(negedge clock);
    check("rst_mid_state", int'(state_a), int'(S_READ));
    check("rst_mid_wr_en", int'(if_a.y_wr_en), 0);
    check("rst_mid_y_out", if_a.y_out, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    got_q.delete();
    src_q.push_back(1);
    src_q.push_back(0);
    push_exp(1, 8);
    wait_outputs(8, "rst");
    tick(20);
    compare_stream("rst");
    clear_sb();

    // Saturation instance: full-scale input against full-scale h[0].
    tick(1);
    if_s.x_in    = 32'h7fffffff;
    if_s.x_empty = 1'b0;
    c = 0;
    while (!if_s.x_rd_en && c < 100) begin
      @(negedge clock);
      c++;
    end
    check("sat_rd_seen", int'(if_s.x_rd_en), 1);
    @(posedge clock); #1;
    if_s.x_empty = 1'b1;
    c = 0;
    while (!if_s.y_wr_en && c < 100) begin
      @(negedge clock);
      c++;
    end
    check("sat_wr_seen", int'(if_s.y_wr_en), 1);
    check("sat_phase0", if_s.y_out, SAT_EXP);

    check("rd_while_empty", bad_rd, 0);
    check("rd_wr_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
